pipe_hazard_control: RTL and testbench
======================================

Name: pipe_hazard_control

Overview:
- Pipeline control unit that generates the `en` and flush inputs for the vector CPU's inter-stage control/data registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards between the ID and EX stages and inserts a one-cycle bubble.
- Freezes the whole pipeline while a multi-cycle vector memory access occupies the MEM stage.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_ADDR_W, 4: width of register-file addresses (scalar and vector files).
- VEC_MEM_LAT, 4: total cycles a vector memory op occupies MEM. Legal range 1..64.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_uses_rs2  in  1  id_rs2 is actually read
- id_rs_vec  in  1  ID sources come from the vector file (0 = scalar file)
- ex_valid  in  1  EX stage holds a real instruction
- ex_rd  in  REG_ADDR_W  EX destination register
- ex_cl_mem_op  in  2  EX memory op: 00 none, 01 load, 10 store, 11 treated as none
- ex_cl_esc_wr  in  2  EX scalar write-back control; nonzero means it writes the scalar file
- ex_cl_vec_wr  in  2  EX vector write-back control; nonzero means it writes the vector file
- mem_vec_start  in  1  pulse: a vector memory op entered MEM this cycle
- en_pc  out  1  PC register enable
- en_if_id  out  1  IF/ID register enable
- en_id_ex  out  1  ID/EX register enable
- en_ex_mem  out  1  EX/MEM register enable
- en_mem_wb  out  1  MEM/WB register enable
- flush_id_ex  out  1  load a bubble (all control zero) into ID/EX
- mem_busy  out  1  vector memory freeze active
- protocol_err  out  1  sticky: mem_vec_start seen while busy
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with en_pc=0

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; internal counter = 0; protocol_err = 0; stall_cycles = 0.
  - All en_* = 0, flush_id_ex = 0, mem_busy = 0 while rst_n is low.
  - First active clock edge after release: FSM in IDLE; outputs follow normal rules.
- Freeze rule (FSM IDLE / BUSY, driven by a down-counter):
  - freeze is high for exactly VEC_MEM_LAT-1 consecutive cycles, starting combinationally in the cycle mem_vec_start is high while IDLE.
  - On that start edge: if VEC_MEM_LAT > 2, go to BUSY with counter = VEC_MEM_LAT-2. Otherwise stay IDLE.
  - In BUSY: freeze = 1 and the counter decrements each cycle. When the counter is 1 at a clock edge, go to IDLE.
  - VEC_MEM_LAT = 1: freeze never asserts.
  - mem_busy = freeze.
- While freeze=1:
  - All five en_* = 0 and flush_id_ex = 0. The load-use check is suppressed and re-evaluated after release.
- Load-use hazard:
  - luh = id_valid & ex_valid & (ex_cl_mem_op == 01) & rs1/rs2 match.
  - rs1/rs2 match: ex_rd == id_rs1, or (id_uses_rs2 & ex_rd == id_rs2).
  - The match only counts in the same register file: ex_cl_vec_wr != 0 when id_rs_vec = 1; ex_cl_esc_wr != 0 when id_rs_vec = 0.
  - Address 0 gets no special treatment.
  - If luh and not freeze: en_pc = 0, en_if_id = 0, flush_id_ex = 1, en_id_ex = 1, en_ex_mem = 1, en_mem_wb = 1.
  - Exactly one bubble per load; the next cycle the load is in MEM and luh is false.
- Otherwise: all en_* = 1 and flush_id_ex = 0.
- Output timing:
  - All en/flush outputs are combinational from FSM state and current inputs; there is no registered latency.
  - protocol_err and stall_cycles are registered.
- Simultaneous events:
  - mem_vec_start together with luh in IDLE: freeze wins.
  - mem_vec_start while BUSY: ignored for timing; protocol_err set on that edge and held until reset.
- stall_cycles: increments on every edge where en_pc = 0 (rst_n high); saturates at all-ones.
- Reset mid-freeze: the freeze aborts immediately; no residual busy cycles after release.

Test Plan:
1. Reset, then release with all inputs 0 -> all en_* = 1, flush_id_ex = 0, mem_busy = 0, stall_cycles = 0.
2. ex_valid = 1, ex_cl_mem_op = 01, ex_cl_esc_wr = 01, ex_rd = 3; id_valid = 1, id_rs_vec = 0, id_rs1 = 3, for one cycle -> en_pc = en_if_id = 0, flush_id_ex = 1, other en = 1. Repeat with id_rs_vec = 1 -> no stall. stall_cycles = 1.
3. VEC_MEM_LAT = 4, mem_vec_start pulsed at cycle t -> mem_busy and all en = 0 in cycles t, t+1, t+2; all en = 1 at t+3; stall_cycles = 3.
4. mem_vec_start at t plus a load-use condition held -> freeze for 3 cycles with flush_id_ex = 0, then a single bubble at t+3; stall_cycles = 4.
5. mem_vec_start again at t+1 while BUSY -> freeze still ends after t+2; protocol_err = 1 from t+2 and stays set.
6. Assert rst_n low at t+1 of a freeze, release at t+3 -> all en = 1 after release; protocol_err = 0; stall_cycles = 0. With VEC_MEM_LAT = 1 -> mem_vec_start causes no stall.

Source files
------------

// File: rtl/pipe_hazard_control.sv
// Pipeline enable/flush generator: load-use bubble insertion and a whole-pipe
// freeze while a multi-cycle vector memory access occupies MEM.
module pipe_hazard_control #(
    parameter int REG_ADDR_W  = 4,
    parameter int VEC_MEM_LAT = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_uses_rs2,
    input  logic                   id_rs_vec,
    input  logic                   ex_valid,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic [1:0]             ex_cl_mem_op,
    input  logic [1:0]             ex_cl_esc_wr,
    input  logic [1:0]             ex_cl_vec_wr,
    input  logic                   mem_vec_start,
    output logic                   en_pc,
    output logic                   en_if_id,
    output logic                   en_id_ex,
    output logic                   en_ex_mem,
    output logic                   en_mem_wb,
    output logic                   flush_id_ex,
    output logic                   mem_busy,
    output logic                   protocol_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int CNT_W = 7;
    localparam bit HAS_FREEZE = (VEC_MEM_LAT > 1);
    localparam bit LONG_OP    = (VEC_MEM_LAT > 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((VEC_MEM_LAT > 2) ? (VEC_MEM_LAT - 2) : 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     r_perr;
    logic [STALL_CNT_W-1:0]   r_stall;

    logic w_start;
    logic w_freeze;
    logic w_file_ok;
    logic w_src_match;
    logic w_luh;
    logic w_en_pc;
    logic w_en_if_id;
    logic w_en_id_ex;
    logic w_en_ex_mem;
    logic w_en_mem_wb;
    logic w_flush;

    // The cycle of the start pulse is itself frozen; BUSY covers the remainder.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_freeze    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start  = mem_vec_start & HAS_FREEZE;
                w_freeze = w_start;
                if (w_start && LONG_OP) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                w_freeze  = 1'b1;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_file_ok   = id_rs_vec ? (|ex_cl_vec_wr) : (|ex_cl_esc_wr);
        w_src_match = (ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2));
        w_luh       = id_valid & ex_valid & (ex_cl_mem_op == 2'b01) & w_src_match & w_file_ok;
    end

    // Everything is held at zero while reset is asserted; freeze outranks the bubble.
    always_comb begin
        w_en_pc     = 1'b0;
        w_en_if_id  = 1'b0;
        w_en_id_ex  = 1'b0;
        w_en_ex_mem = 1'b0;
        w_en_mem_wb = 1'b0;
        w_flush     = 1'b0;
        if (rst_n && !w_freeze) begin
            w_en_id_ex  = 1'b1;
            w_en_ex_mem = 1'b1;
            w_en_mem_wb = 1'b1;
            if (w_luh) begin
                w_flush = 1'b1;
            end else begin
                w_en_pc    = 1'b1;
                w_en_if_id = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_perr  <= 1'b0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == S_BUSY) && mem_vec_start) begin
                r_perr <= 1'b1;
            end
            if (!w_en_pc && (r_stall != '1)) begin
                r_stall <= r_stall + STALL_CNT_W'(1);
            end
        end
    end

    assign en_pc        = w_en_pc;
    assign en_if_id     = w_en_if_id;
    assign en_id_ex     = w_en_id_ex;
    assign en_ex_mem    = w_en_ex_mem;
    assign en_mem_wb    = w_en_mem_wb;
    assign flush_id_ex  = w_flush;
    assign mem_busy     = rst_n & w_freeze;
    assign protocol_err = r_perr;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_hazard_control.sv
// Bench for pipe_hazard_control: directed scenarios then random traffic, checked
// against a cycle-count reference model on two instances (latency 4 and 1).
module tb_pipe_hazard_control;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;
    localparam int SAT_A = 65535;
    localparam int SAT_B = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs2, id_rs_vec, ex_valid, mem_vec_start;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic [1:0] ex_cl_mem_op, ex_cl_esc_wr, ex_cl_vec_wr;

    logic        a_en_pc, a_en_if_id, a_en_id_ex, a_en_ex_mem, a_en_mem_wb, a_flush, a_busy, a_perr;
    logic [15:0] a_stall;
    logic        b_en_pc, b_en_if_id, b_en_id_ex, b_en_ex_mem, b_en_mem_wb, b_flush, b_busy, b_perr;
    logic [2:0]  b_stall;

    int checks = 0;
    int errors = 0;

    // reference model state: future freeze cycles owed, sticky error, stall count
    int bl_a, bl_b, stall_a, stall_b;
    bit perr_a, perr_b;

    always #5 clk = ~clk;

    pipe_hazard_control #(.REG_ADDR_W(4), .VEC_MEM_LAT(LAT_A), .STALL_CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_rs_vec(id_rs_vec), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_cl_mem_op(ex_cl_mem_op), .ex_cl_esc_wr(ex_cl_esc_wr), .ex_cl_vec_wr(ex_cl_vec_wr),
        .mem_vec_start(mem_vec_start), .en_pc(a_en_pc), .en_if_id(a_en_if_id),
        .en_id_ex(a_en_id_ex), .en_ex_mem(a_en_ex_mem), .en_mem_wb(a_en_mem_wb),
        .flush_id_ex(a_flush), .mem_busy(a_busy), .protocol_err(a_perr), .stall_cycles(a_stall)
    );

    pipe_hazard_control #(.REG_ADDR_W(4), .VEC_MEM_LAT(LAT_B), .STALL_CNT_W(3)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .id_rs_vec(id_rs_vec), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_cl_mem_op(ex_cl_mem_op), .ex_cl_esc_wr(ex_cl_esc_wr), .ex_cl_vec_wr(ex_cl_vec_wr),
        .mem_vec_start(mem_vec_start), .en_pc(b_en_pc), .en_if_id(b_en_if_id),
        .en_id_ex(b_en_id_ex), .en_ex_mem(b_en_ex_mem), .en_mem_wb(b_en_mem_wb),
        .flush_id_ex(b_flush), .mem_busy(b_busy), .protocol_err(b_perr), .stall_cycles(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_luh();
        bit same_file, uses_reg;
        same_file = id_rs_vec ? (ex_cl_vec_wr != 2'b00) : (ex_cl_esc_wr != 2'b00);
        uses_reg  = (ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2));
        return id_valid && ex_valid && (ex_cl_mem_op == 2'b01) && same_file && uses_reg;
    endfunction

    // {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_id_ex}
    function automatic logic [5:0] exp_ctrl(input bit frz, input bit luh);
        if (frz) return 6'b000000;
        if (luh) return 6'b001111;
        return 6'b111110;
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; id_rs_vec = 0;
        ex_valid = 0; ex_rd = 0; ex_cl_mem_op = 0; ex_cl_esc_wr = 0; ex_cl_vec_wr = 0;
        mem_vec_start = 0;
    endtask

    // Entered just after a rising edge; checks mid-cycle, then advances the model over the edge.
    task automatic do_cycle();
        bit luh, fa, fb;
        logic [5:0] ea, eb;
        @(negedge clk);
        luh = model_luh();
        fa  = (bl_a > 0) || (mem_vec_start && LAT_A >= 2);
        fb  = (bl_b > 0) || (mem_vec_start && LAT_B >= 2);
        ea  = exp_ctrl(fa, luh);
        eb  = exp_ctrl(fb, luh);
        chk("ctrl_a", {a_en_pc, a_en_if_id, a_en_id_ex, a_en_ex_mem, a_en_mem_wb, a_flush}, ea);
        chk("busy_a", a_busy, fa);
        chk("perr_a", a_perr, perr_a);
        chk("stall_a", a_stall, stall_a);
        chk("ctrl_b", {b_en_pc, b_en_if_id, b_en_id_ex, b_en_ex_mem, b_en_mem_wb, b_flush}, eb);
        chk("busy_b", b_busy, fb);
        chk("perr_b", b_perr, perr_b);
        chk("stall_b", b_stall, stall_b);
        if (!ea[5] && stall_a < SAT_A) stall_a++;
        if (!eb[5] && stall_b < SAT_B) stall_b++;
        if (bl_a > 0) begin
            if (mem_vec_start) perr_a = 1;
            bl_a--;
        end else if (fa) bl_a = LAT_A - 2;
        if (bl_b > 0) begin
            if (mem_vec_start) perr_b = 1;
            bl_b--;
        end else if (fb) bl_b = LAT_B - 2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 0;
        #2;
        chk("rst_ctrl_a", {a_en_pc, a_en_if_id, a_en_id_ex, a_en_ex_mem, a_en_mem_wb, a_flush, a_busy}, 0);
        chk("rst_perr_a", a_perr, 0);
        chk("rst_stall_a", a_stall, 0);
        chk("rst_ctrl_b", {b_en_pc, b_en_if_id, b_en_id_ex, b_en_ex_mem, b_en_mem_wb, b_flush, b_busy}, 0);
        chk("rst_stall_b", b_stall, 0);
        bl_a = 0; bl_b = 0; perr_a = 0; perr_b = 0; stall_a = 0; stall_b = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic set_load_use(input bit vec);
        ex_valid = 1; ex_cl_mem_op = 2'b01; ex_cl_esc_wr = 2'b01; ex_cl_vec_wr = 2'b00; ex_rd = 4'd3;
        id_valid = 1; id_rs_vec = vec; id_rs1 = 4'd3; id_rs2 = 4'd0; id_uses_rs2 = 0;
    endtask

    initial begin
        rst_n = 1;
        clear_inputs();
        #1;
        // reset release with idle inputs
        do_reset(2);
        do_cycle();
        do_cycle();
        // scalar load-use bubble, then mismatched register file
        set_load_use(0);
        do_cycle();
        set_load_use(1);
        do_cycle();
        clear_inputs();
        do_cycle();
        chk("stall_after_bubble", a_stall, 1);
        // plain vector-memory freeze
        mem_vec_start = 1;
        do_cycle();
        mem_vec_start = 0;
        repeat (4) do_cycle();
        chk("stall_after_freeze", a_stall, 4);
        // freeze overlapping a held load-use condition
        set_load_use(0);
        mem_vec_start = 1;
        do_cycle();
        mem_vec_start = 0;
        repeat (3) do_cycle();
        clear_inputs();
        do_cycle();
        chk("stall_after_overlap", a_stall, 8);
        // second start while busy
        mem_vec_start = 1;
        do_cycle();
        do_cycle();
        mem_vec_start = 0;
        repeat (3) do_cycle();
        chk("perr_sticky", a_perr, 1);
        // reset in the middle of a freeze
        mem_vec_start = 1;
        do_cycle();
        mem_vec_start = 0;
        do_reset(2);
        do_cycle();
        do_cycle();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 4'($urandom_range(0, 3));
            id_rs2        = 4'($urandom_range(0, 3));
            id_uses_rs2   = 1'($urandom_range(0, 1));
            id_rs_vec     = 1'($urandom_range(0, 1));
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_rd         = 4'($urandom_range(0, 3));
            ex_cl_mem_op  = 2'($urandom_range(0, 3));
            ex_cl_esc_wr  = 2'($urandom_range(0, 3));
            ex_cl_vec_wr  = 2'($urandom_range(0, 3));
            mem_vec_start = ($urandom_range(0, 5) == 0);
            if (i == 200) do_reset(1);
            do_cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
